// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Constants shared by the VGA timing state machines and the line fetch
//   scheduler: display geometry, framebuffer word packing, SRAM and
//   line-buffer address widths, and the fetch scheduler state encoding.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Display geometry
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PIX_PER_WORD = 4;
  localparam int WORDS        = H_ACTIVE / PIX_PER_WORD;  // SRAM words per line

  // Framebuffer SRAM
  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;  // covers WORDS * V_ACTIVE = 76800 words

  // Counter widths
  localparam int WIDX_W    = $clog2(WORDS);         // word index within a line
  localparam int LINE_W    = $clog2(V_ACTIVE + 1);  // 0..V_ACTIVE inclusive
  localparam int LB_ADDR_W = 1 + WIDX_W;            // {bank, word index}

  // Sized versions of the constants so comparisons and sums stay width-exact
  localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(WORDS - 1);
  localparam logic [LINE_W-1:0] LINE_LIMIT  = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(WORDS);

  // Fetch scheduler state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // SRAM port owned by the host writer
    FETCH = 2'd1,  // one SRAM read per cycle for the current line
    DRAIN = 2'd2   // capture the final read into the line buffer
  } fetch_state_e;

endpackage : vga_timing_pkg

// File: rtl/vga_line_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// vga_line_fetch_scheduler
//   Arbitrates the single-port framebuffer SRAM between display line fetches
//   and a host writer. A frame start or an end-of-active-line pulse launches
//   a fetch of one display line (WORDS reads) into a ping-pong line buffer;
//   the bank is the line number's LSB so the bank being displayed is never
//   overwritten. Whenever no fetch runs the SRAM port is handed to the host
//   through a valid/ready handshake with zero-cycle latency.
//
// Ports
//   clk_i, rst_ni          pixel clock, asynchronous active-low reset
//   frame_start_i          pulse: restart at line 0 (aborts any fetch)
//   line_end_i             pulse: fetch the next line if idle, else underrun
//   host_valid_i/_ready_o  host write handshake (ready is combinational)
//   host_addr_i/_data_i    host write address / data
//   mem_en_o/_we_o         SRAM enable / write enable
//   mem_addr_o/_wdata_o    SRAM address / write data
//   mem_rdata_i            SRAM read data, one cycle after the read
//   lb_we_o/_addr_o/_wdata_o  line-buffer write port ({bank, word index})
//   fetch_busy_o           a fetch (FETCH or DRAIN) is in progress
//   underrun_o             sticky: line_end_i arrived during a fetch
// -----------------------------------------------------------------------------
module vga_line_fetch_scheduler
  import vga_timing_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 frame_start_i,
  input  logic                 line_end_i,
  input  logic                 host_valid_i,
  output logic                 host_ready_o,
  input  logic [ADDR_W-1:0]    host_addr_i,
  input  logic [DATA_W-1:0]    host_data_i,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 lb_we_o,
  output logic [LB_ADDR_W-1:0] lb_addr_o,
  output logic [DATA_W-1:0]    lb_wdata_o,
  output logic                 fetch_busy_o,
  output logic                 underrun_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e        state_q,      state_d;
  logic [LINE_W-1:0]   next_line_q,  next_line_d;   // line the next line_end fetches
  logic [ADDR_W-1:0]   line_base_q,  line_base_d;   // next_line * WORDS, kept by addition
  logic [WIDX_W-1:0]   word_idx_q,   word_idx_d;    // word being read this cycle
  logic                cur_bank_q,   cur_bank_d;    // bank of the line being fetched
  logic                rd_pending_q, rd_pending_d;  // a read was issued last cycle
  logic [WIDX_W-1:0]   rd_idx_q,     rd_idx_d;      // word index of that read
  logic                rd_bank_q,    rd_bank_d;     // bank of that read
  logic                underrun_q,   underrun_d;

  logic busy;
  logic host_fire;

  assign busy      = (state_q != IDLE);
  assign host_fire = host_valid_i && host_ready_o;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    next_line_d = next_line_q;
    line_base_d = line_base_q;
    word_idx_d  = word_idx_q;
    cur_bank_d  = cur_bank_q;
    underrun_d  = underrun_q;

    // The read pipeline simply follows whatever was issued this cycle. The
    // bank travels with the read so that a read issued in the cycle a frame
    // start aborts the fetch still lands in the bank of its own line.
    rd_pending_d = (state_q == FETCH);
    rd_idx_d     = word_idx_q;
    rd_bank_d    = cur_bank_q;

    if (frame_start_i) begin
      // Highest priority: restart the frame from line 0 in any state.
      state_d     = FETCH;
      next_line_d = '0;
      line_base_d = '0;
      word_idx_d  = '0;
      cur_bank_d  = 1'b0;
    end else begin
      // A line end during a fetch cannot be serviced; flag it and drop it.
      if (line_end_i && busy) begin
        underrun_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          // After the last active line the pulses keep coming through the
          // blanking interval; they must not launch fetches.
          if (line_end_i && (next_line_q < LINE_LIMIT)) begin
            state_d    = FETCH;
            word_idx_d = '0;
            cur_bank_d = next_line_q[0];
          end
        end

        FETCH: begin
          if (word_idx_q == LAST_WORD) begin
            state_d    = DRAIN;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
          end
        end

        DRAIN: begin
          state_d     = IDLE;
          next_line_d = next_line_q + LINE_W'(1);
          line_base_d = line_base_q + LINE_STRIDE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM port mux and host handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    host_ready_o = (state_q == IDLE) && !frame_start_i && !line_end_i;

    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    if (state_q == FETCH) begin
      mem_en_o   = 1'b1;
      mem_addr_o = line_base_q + ADDR_W'(word_idx_q);
    end else if (host_fire) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Line-buffer write port: SRAM data is written the cycle it returns
  // ---------------------------------------------------------------------------
  assign lb_we_o      = rd_pending_q;
  assign lb_addr_o    = {rd_bank_q, rd_idx_q};
  assign lb_wdata_o   = mem_rdata_i;
  assign fetch_busy_o = busy;
  assign underrun_o   = underrun_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      next_line_q  <= '0;
      line_base_q  <= '0;
      word_idx_q   <= '0;
      cur_bank_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_line_q  <= next_line_d;
      line_base_q  <= line_base_d;
      word_idx_q   <= word_idx_d;
      cur_bank_q   <= cur_bank_d;
      rd_pending_q <= rd_pending_d;
      rd_idx_q     <= rd_idx_d;
      rd_bank_q    <= rd_bank_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule : vga_line_fetch_scheduler

// File: tb/tb_vga_line_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_line_fetch_scheduler
//   Directed stimulus for the line fetch scheduler. A cycle-based model tracks
//   how many cycles have elapsed since the last accepted trigger and derives
//   every output from that age; a negedge process compares the DUT with it on
//   every cycle. Hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_vga_line_fetch_scheduler;
  import vga_timing_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 frame_start_i = 1'b0;
  logic                 line_end_i = 1'b0;
  logic                 host_valid_i = 1'b0;
  logic                 host_ready_o;
  logic [ADDR_W-1:0]    host_addr_i = '0;
  logic [DATA_W-1:0]    host_data_i = '0;
  logic                 mem_en_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [DATA_W-1:0]    mem_wdata_o;
  logic [DATA_W-1:0]    mem_rdata_i = '0;
  logic                 lb_we_o;
  logic [LB_ADDR_W-1:0] lb_addr_o;
  logic [DATA_W-1:0]    lb_wdata_o;
  logic                 fetch_busy_o;
  logic                 underrun_o;

  vga_line_fetch_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_start_i (frame_start_i),
    .line_end_i    (line_end_i),
    .host_valid_i  (host_valid_i),
    .host_ready_o  (host_ready_o),
    .host_addr_i   (host_addr_i),
    .host_data_i   (host_data_i),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .lb_we_o       (lb_we_o),
    .lb_addr_o     (lb_addr_o),
    .lb_wdata_o    (lb_wdata_o),
    .fetch_busy_o  (fetch_busy_o),
    .underrun_o    (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // SRAM model: a read at address A returns A+0x100 on the following cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sram_nxt = 16'hDEAD;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      mem_rdata_i = sram_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: 'age' = cycles since the accepted trigger (0 = idle).
  // Busy for ages 1..161, reads for ages 1..160 at line*WORDS + age-1.
  // ---------------------------------------------------------------------------
  int age = 0, m_line = 0, m_nl = 0;
  bit m_under = 0;
  bit pv = 0;
  int pa = 0, pb = 0, pidx = 0;
  bit e_busy, e_rd, e_rdy, e_hw;
  int e_addr;

  always @(negedge clk_i) begin
    sram_nxt = (mem_en_o && !mem_we_o) ? 16'(mem_addr_o + 17'h100) : 16'hDEAD;
    if (!rst_ni) begin
      chk("rst busy", fetch_busy_o, 0);
      chk("rst mem_en", mem_en_o, 0);
      chk("rst lb_we", lb_we_o, 0);
      chk("rst underrun", underrun_o, 0);
      age = 0; m_line = 0; m_nl = 0; m_under = 0; pv = 0;
    end else begin
      e_busy = (age >= 1) && (age <= WORDS + 1);
      e_rd   = (age >= 1) && (age <= WORDS);
      e_rdy  = !e_busy && !frame_start_i && !line_end_i;
      e_hw   = e_rdy && host_valid_i;
      e_addr = m_line * WORDS + age - 1;

      chk("m busy", fetch_busy_o, e_busy);
      chk("m host_ready", host_ready_o, e_rdy);
      chk("m mem_en", mem_en_o, e_rd || e_hw);
      chk("m mem_we", mem_we_o, e_hw);
      if (e_rd) chk("m rd addr", mem_addr_o, e_addr);
      if (e_hw) begin
        chk("m wr addr", mem_addr_o, host_addr_i);
        chk("m wr data", mem_wdata_o, host_data_i);
      end
      chk("m lb_we", lb_we_o, pv);
      if (pv) begin
        chk("m lb_addr", lb_addr_o, pb * 256 + pidx);
        chk("m lb_wdata", lb_wdata_o, (pa + 32'h100) & 32'hFFFF);
      end
      chk("m underrun", underrun_o, m_under);

      // advance the model by one cycle
      pv = e_rd; pa = e_addr; pb = m_line % 2; pidx = age - 1;
      if (line_end_i && e_busy && !frame_start_i) m_under = 1;
      if (frame_start_i) begin
        age = 1; m_line = 0;
      end else if (!e_busy) begin
        if (line_end_i && (m_nl < V_ACTIVE)) begin
          age = 1; m_line = m_nl;
        end
      end else begin
        age++;
        if (age == WORDS + 2) begin
          age = 0; m_nl = m_line + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset
    rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    #2;
    chk("reset busy", fetch_busy_o, 0);
    chk("reset mem_en", mem_en_o, 0);
    chk("reset lb_we", lb_we_o, 0);
    chk("reset underrun", underrun_o, 0);
    chk("reset host_ready", host_ready_o, 1);
    $display("phase reset: done");

    // A: frame start fetches line 0 into bank 0
    tick(); frame_start_i = 1'b1;
    tick(); frame_start_i = 1'b0;
    #2;
    chk("A first rd addr", mem_addr_o, 0);
    chk("A first rd en", mem_en_o, 1);
    for (int i = 2; i <= 162; i++) begin
      tick(); #2;
      if (i == 2)   begin chk("A lb first addr", lb_addr_o, 0);   chk("A lb first data", lb_wdata_o, 16'h100); end
      if (i == 160) chk("A last rd addr", mem_addr_o, 159);
      if (i == 161) begin chk("A lb last addr", lb_addr_o, 159); chk("A lb last data", lb_wdata_o, 16'h19F); end
      if (i == 162) chk("A busy low", fetch_busy_o, 0);
    end
    $display("phase A: line 0 fetch done");

    // B: line end fetches line 1 into bank 1
    tick(); line_end_i = 1'b1;
    #2 chk("B ready low", host_ready_o, 0);
    tick(); line_end_i = 1'b0;
    #2 chk("B first rd addr", mem_addr_o, 160);
    for (int i = 2; i <= 162; i++) begin
      tick(); #2;
      if (i == 2)   begin chk("B lb first addr", lb_addr_o, 256); chk("B lb first data", lb_wdata_o, 16'h1A0); end
      if (i == 160) chk("B last rd addr", mem_addr_o, 319);
      if (i == 161) chk("B lb last addr", lb_addr_o, 415);
    end
    $display("phase B: line 1 fetch done");

    // C: host request collides with a line end; fetch wins, write follows
    tick(); line_end_i = 1'b1; host_valid_i = 1'b1;
    host_addr_i = 17'h1ABCD; host_data_i = 16'hBEEF;
    #2;
    chk("C ready low", host_ready_o, 0);
    chk("C no write", mem_we_o, 0);
    tick(); line_end_i = 1'b0;
    for (int i = 2; i <= 162; i++) begin
      tick(); #2;
      if (i == 161) chk("C ready in drain", host_ready_o, 0);
      if (i == 162) begin
        chk("C ready", host_ready_o, 1);
        chk("C we", mem_we_o, 1);
        chk("C addr", mem_addr_o, 17'h1ABCD);
        chk("C wdata", mem_wdata_o, 16'hBEEF);
      end
    end
    tick(); host_valid_i = 1'b0;
    $display("phase C: host write after line 2 fetch done");

    // E: frame start at T+80 of the line-3 fetch restarts at line 0
    tick(); line_end_i = 1'b1;
    tick(); line_end_i = 1'b0;
    for (int i = 2; i <= 79; i++) tick();
    tick(); frame_start_i = 1'b1;
    #2 chk("E rd before abort", mem_addr_o, 559);
    tick(); frame_start_i = 1'b0;
    #2;
    chk("E restart addr", mem_addr_o, 0);
    chk("E underrun", underrun_o, 0);
    tick(); #2;
    chk("E lb bank0", lb_addr_o, 0);
    for (int i = 3; i <= 162; i++) tick();
    #2 chk("E busy low", fetch_busy_o, 0);
    $display("phase E: frame-start abort done");

    // D: line end at T+50 of the line-1 fetch raises underrun
    tick(); line_end_i = 1'b1;
    tick(); line_end_i = 1'b0;
    for (int i = 2; i <= 162; i++) begin
      tick();
      if (i == 50) line_end_i = 1'b1;
      if (i == 51) line_end_i = 1'b0;
      #2;
      if (i == 51) begin chk("D underrun set", underrun_o, 1); chk("D rd continues", mem_addr_o, 210); end
      if (i == 162) chk("D busy low", fetch_busy_o, 0);
    end
    repeat (5) tick();
    #2;
    chk("D no second fetch", fetch_busy_o, 0);
    chk("D underrun sticky", underrun_o, 1);
    $display("phase D: underrun done");

    // F: a full frame of 480 lines, then one extra line end
    tick(); frame_start_i = 1'b1;
    tick(); frame_start_i = 1'b0;
    repeat (161) tick();
    for (int ln = 1; ln < V_ACTIVE; ln++) begin
      tick(); line_end_i = 1'b1;
      tick(); line_end_i = 1'b0;
      for (int i = 2; i <= 162; i++) begin
        tick();
        if (ln == V_ACTIVE - 1 && i == 160) begin
          #2 chk("F last frame addr", mem_addr_o, 76799);
        end
      end
    end
    tick(); line_end_i = 1'b1;
    tick(); line_end_i = 1'b0;
    #2;
    chk("F extra no busy", fetch_busy_o, 0);
    chk("F extra no read", mem_en_o, 0);
    $display("phase F: full frame done");

    // G: reset in the middle of a fetch
    tick(); frame_start_i = 1'b1;
    tick(); frame_start_i = 1'b0;
    repeat (30) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("G lb_we cleared", lb_we_o, 0);
    chk("G busy cleared", fetch_busy_o, 0);
    chk("G underrun cleared", underrun_o, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick(); #2;
    chk("G idle busy", fetch_busy_o, 0);
    chk("G idle lb_we", lb_we_o, 0);
    chk("G idle ready", host_ready_o, 1);
    $display("phase G: reset mid-fetch done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_vga_line_fetch_scheduler

// File: doc/vga_line_fetch_scheduler.md
# vga_line_fetch_scheduler

Schedules framebuffer reads for the VGA display path and shares the single-port framebuffer SRAM with a host writer. Fetch triggers come from the timing state machines: frame start and end of each active line. On each trigger the block reads one display line from SRAM into a ping-pong line buffer. When no fetch is running, the SRAM port goes to the host write requester through a valid/ready handshake.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- PIX_PER_WORD, 4, pixels packed per SRAM word; WORDS = H_ACTIVE/PIX_PER_WORD = 160
- DATA_W, 16, SRAM word width
- ADDR_W, 17, SRAM address width (must cover WORDS*V_ACTIVE)
- LB_ADDR_W, 9, line-buffer address width: {bank bit, word index}

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous, active-low reset
- frame_start_i  in  1  one-cycle pulse, start of vertical back porch
- line_end_i  in  1  one-cycle pulse, end of each active line
- host_valid_i  in  1  host write request
- host_ready_o  out  1  host write accepted this cycle
- host_addr_i  in  ADDR_W  host write address
- host_data_i  in  DATA_W  host write data
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  ADDR_W  SRAM address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_rdata_i  in  DATA_W  SRAM read data, valid 1 cycle after a read
- lb_we_o  out  1  line-buffer write enable
- lb_addr_o  out  LB_ADDR_W  line-buffer address
- lb_wdata_o  out  DATA_W  line-buffer write data
- fetch_busy_o  out  1  state != IDLE
- underrun_o  out  1  sticky: a line_end_i arrived while a fetch was in progress

## Operation
- States:
  - IDLE: SRAM port belongs to the host.
  - FETCH: issues WORDS reads.
  - DRAIN: waits one cycle to capture the last read.
- Registers:
  - next_line (0..V_ACTIVE)
  - line_base (ADDR_W), advanced by +WORDS per accepted line; no multiplier
  - word_idx (0..WORDS-1)
  - cur_bank
  - rd_pending, plus the delayed index for line-buffer writes
- Trigger priority: frame_start_i, then line_end_i, then host.
  - frame_start_i in any state: abort the current fetch (no underrun), set next_line=0, line_base=0, and enter FETCH for line 0. Bank = line[0].
  - line_end_i in IDLE with next_line < V_ACTIVE: enter FETCH for next_line.
  - line_end_i in IDLE with next_line == V_ACTIVE: ignored, no fetch.
  - line_end_i in FETCH or DRAIN: set underrun_o. The fetch continues unaffected and the trigger is dropped.
- FETCH, each cycle:
  - mem_en_o=1, mem_we_o=0, mem_addr_o=line_base+word_idx.
  - word_idx increments; after word_idx==WORDS-1, go to DRAIN.
- One cycle after each read: lb_we_o=1, lb_addr_o={bank, idx of that read}, lb_wdata_o=mem_rdata_i.
- DRAIN: last line-buffer write, then go to IDLE. On exit, next_line+=1 and line_base+=WORDS.
- Host path:
  - host_ready_o = (state==IDLE) && !frame_start_i && !line_end_i, combinational.
  - On valid&&ready: mem_en_o=1, mem_we_o=1, mem_addr_o=host_addr_i, mem_wdata_o=host_data_i in the same cycle.
- Reset values:
  - state IDLE.
  - All counters 0.
  - underrun_o=0, fetch_busy_o=0, mem_en_o/mem_we_o/lb_we_o=0.
  - host_ready_o=1 once idle with no trigger.
- Reset mid-fetch: the fetch is abandoned immediately and no further line-buffer writes occur.
- underrun_o clears only on reset.

## Timing
- Trigger sampled at cycle T.
  - Reads issue at T+1..T+WORDS.
  - Line-buffer writes occur at T+2..T+WORDS+1.
  - IDLE at T+WORDS+2.
- fetch_busy_o is high T+1..T+WORDS+1, i.e. WORDS+1 = 161 cycles.
- Host writes have 0-cycle latency and are never issued while fetch_busy_o=1.
- A line fetch spans part of the next line's display. The ping-pong bank keeps the displayed bank untouched.

## Structure
- Shared package vga_timing_pkg holds:
  - H_ACTIVE, V_ACTIVE, PIX_PER_WORD, derived WORDS, LB_ADDR_W
  - state encoding localparams (IDLE=0, FETCH=1, DRAIN=2)
- The timing state machines use the same package constants.
- No sub-module; single-module implementation.

## Test plan
- Reset: hold rst_ni=0 then release. Required: fetch_busy_o=0, mem_en_o=0, lb_we_o=0, underrun_o=0. host_ready_o=1 with no triggers.
- frame_start_i pulse at T, mem_rdata_i=addr+0x100. Required:
  - mem_addr_o 0..159 at T+1..T+160.
  - lb_addr_o 0..159 with data 0x100..0x19F at T+2..T+161.
  - fetch_busy_o low at T+162.
- After that fetch, a line_end_i pulse. Required: reads at 160..319; line-buffer writes to bank 1, lb_addr_o 256..415.
- host_valid_i held high with line_end_i in the same cycle. Required: host_ready_o=0, fetch wins. The host write completes at T+162 with mem_we_o=1 and the host address.
- line_end_i at T+50 of a fetch. Required: underrun_o=1 and stays high; fetch completes 160 reads; no second fetch starts.
- frame_start_i at T+80 of a line-3 fetch. Required: reads restart at address 0, bank 0, underrun_o unchanged. Separately, after 480 line fetches a further line_end_i produces no read.
